mem_access_unit: RTL and testbench

Memory-stage load/store unit between the EX/MEM pipeline register and the MEM/WB pipeline register. Converts byte/halfword/word loads and stores into aligned word accesses on a data-memory port with a req/ack handshake. Stalls the upstream pipeline while the access is outstanding. Returns lane-aligned, sign- or zero-extended load data plus pass-through control for write-back.

---
 rtl/mem_access_unit.sv | 112 +++++++++++
 tb/tb_mem_access_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage load/store unit driving a req/ack data-memory port
module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ALUResult,
    input  logic [31:0] writeData,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  accessSize,
    input  logic        loadUnsigned,
    input  logic [4:0]  writeRegister,
    input  logic        MemtoReg,
    input  logic        RegWriteEn,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [29:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        memStall,
    output logic [31:0] memoryReadData,
    output logic [4:0]  writeRegister_out,
    output logic        MemtoReg_out,
    output logic        RegWriteEn_out,
    output logic        misalignErr
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    state_t      state_q, state_d;
    logic        req_q, req_d, we_q, we_d, uns_q, uns_d;
    logic [1:0]  size_q, size_d, off_q, off_d;
    logic [29:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [3:0]  be_q, be_d;
    logic        access, misalign, start;
    logic [31:0] st_wdata, ext;
    logic [3:0]  st_be;
    logic [7:0]  lb;
    logic [15:0] lh;

    // decode the incoming access; reserved size 11 behaves as a word
    always_comb begin
        access   = MemRead | MemWrite;
        misalign = access & (accessSize == 2'b01 ? ALUResult[0] : accessSize[1] ? |ALUResult[1:0] : 1'b0);
        start    = state_q == IDLE && access && !misalign;
        st_wdata = accessSize == 2'b00 ? {4{writeData[7:0]}} : accessSize == 2'b01 ? {2{writeData[15:0]}} : writeData;
        st_be    = accessSize == 2'b00 ? 4'b0001 << ALUResult[1:0] : accessSize == 2'b01 ? (ALUResult[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    end

    // pick the addressed lane of the returned word and extend it using the latched access shape
    always_comb begin
        lb  = dmem_rdata[{off_q, 3'b000} +: 8];
        lh  = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        ext = size_q == 2'b00 ? {{24{~uns_q & lb[7]}}, lb} : size_q == 2'b01 ? {{16{~uns_q & lh[15]}}, lh} : dmem_rdata;
    end

    // next state; the access is latched on entry to REQ so EX/MEM is not relied on afterwards
    always_comb begin
        state_d = start ? REQ : state_q == REQ ? (dmem_ack ? DONE : REQ) : IDLE;
        req_d   = start | (state_q == REQ & ~dmem_ack);
        addr_d  = start ? ALUResult[31:2] : addr_q;
        wdata_d = start ? st_wdata : wdata_q;
        be_d    = start ? st_be : be_q;
        we_d    = start ? MemWrite & ~MemRead : we_q;
        size_d  = start ? accessSize : size_q;
        uns_d   = start ? loadUnsigned : uns_q;
        off_d   = start ? ALUResult[1:0] : off_q;
        rdata_d = (state_q == REQ && dmem_ack) ? (we_q ? 32'd0 : ext) : rdata_q;
    end

    // state and latched access registers, cleared by asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'b00;
            off_q   <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            uns_q   <= uns_d;
            size_q  <= size_d;
            off_q   <= off_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
        end
    end

    // stage outputs; a misaligned access retires as a bubble without stalling
    always_comb begin
        memStall          = rst & (start | state_q == REQ);
        misalignErr       = rst & (state_q == IDLE) & misalign;
        memoryReadData    = state_q == DONE ? rdata_q : 32'd0;
        writeRegister_out = writeRegister;
        MemtoReg_out      = MemtoReg;
        RegWriteEn_out    = RegWriteEn & ~misalignErr;
        dmem_req          = req_q;
        dmem_we           = we_q;
        dmem_addr         = addr_q;
        dmem_wdata        = wdata_q;
        dmem_be           = be_q;
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and randomized checks of mem_access_unit against a byte-level model
module tb_mem_access_unit;
    logic        clk = 0, rst = 1;
    logic [31:0] ALUResult = 0, writeData = 0, dmem_rdata = 0;
    logic        MemRead = 0, MemWrite = 0, loadUnsigned = 0, MemtoReg = 0, RegWriteEn = 0, dmem_ack = 0;
    logic [1:0]  accessSize = 0;
    logic [4:0]  writeRegister = 0;
    logic        dmem_req, dmem_we, memStall, MemtoReg_out, RegWriteEn_out, misalignErr;
    logic [29:0] dmem_addr;
    logic [31:0] dmem_wdata, memoryReadData;
    logic [3:0]  dmem_be;
    logic [4:0]  writeRegister_out;

    int vectors = 0, miscompares = 0;

    int          o_stall, o_reqcyc;
    logic        o_mis, o_rwe, o_req_idle, o_we, o_stable;
    logic [29:0] o_addr;
    logic [3:0]  o_be;
    logic [31:0] o_wdata, o_rd;

    mem_access_unit dut (
        .clk(clk), .rst(rst), .ALUResult(ALUResult), .writeData(writeData),
        .MemRead(MemRead), .MemWrite(MemWrite), .accessSize(accessSize), .loadUnsigned(loadUnsigned),
        .writeRegister(writeRegister), .MemtoReg(MemtoReg), .RegWriteEn(RegWriteEn),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_be(dmem_be), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .memStall(memStall),
        .memoryReadData(memoryReadData), .writeRegister_out(writeRegister_out),
        .MemtoReg_out(MemtoReg_out), .RegWriteEn_out(RegWriteEn_out), .misalignErr(misalignErr)
    );

    always #5 clk = ~clk;

    function automatic int nbytes(input logic [1:0] sz);
        return sz == 2'b00 ? 1 : sz == 2'b01 ? 2 : 4;
    endfunction

    function automatic logic ref_mis(input logic [31:0] a, input logic [1:0] sz);
        return (int'(a[1:0]) % nbytes(sz)) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [31:0] a, input logic [1:0] sz, input logic uns);
        int nb;
        longint w, v, span;
        nb = nbytes(sz);
        if (nb == 4) return word;
        w = longint'(word);
        span = 64'd1 << (8 * nb);
        v = (w >> (8 * int'(a[1:0]))) % span;
        if (!uns && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    function automatic logic [3:0] ref_be(input logic [31:0] a, input logic [1:0] sz);
        logic [3:0] be;
        int nb, off;
        nb = nbytes(sz);
        off = nb == 4 ? 0 : int'(a[1:0]);
        for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + nb);
        return be;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [31:0] wd, input logic [1:0] sz);
        logic [31:0] r;
        int nb;
        nb = nbytes(sz);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = 8'((wd >> (8 * (i % nb))) & 32'hFF);
        return r;
    endfunction

    // drives one access starting in an IDLE cycle; ack comes in REQ cycle n; records observations only
    task automatic run_access(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                              input logic [31:0] a, input logic [31:0] wd, input logic [31:0] word, input int n);
        MemRead = rd; MemWrite = wr; accessSize = sz; loadUnsigned = uns;
        ALUResult = a; writeData = wd; dmem_rdata = word; RegWriteEn = 1; writeRegister = 5'd7; MemtoReg = rd;
        o_stall = 0; o_reqcyc = 0; o_stable = 1; o_rd = 0;
        o_addr = 0; o_be = 0; o_we = 0; o_wdata = 0;
        @(negedge clk);
        o_mis = misalignErr; o_rwe = RegWriteEn_out; o_req_idle = dmem_req;
        if (memStall) begin
            o_stall++;
            @(posedge clk); #1;
            for (int k = 0; k < n; k++) begin
                @(negedge clk);
                if (memStall) o_stall++;
                if (dmem_req) o_reqcyc++;
                if (k == 0) begin
                    o_addr = dmem_addr; o_be = dmem_be; o_we = dmem_we; o_wdata = dmem_wdata;
                end else if (dmem_addr !== o_addr || dmem_be !== o_be || dmem_wdata !== o_wdata || dmem_we !== o_we) o_stable = 0;
                dmem_ack = (k == n - 1);
                @(posedge clk); #1;
                dmem_ack = 0;
            end
            @(negedge clk);
            if (memStall) o_stall++;
            if (dmem_req) o_reqcyc++;
            o_rd = memoryReadData;
        end
        @(posedge clk); #1;
        MemRead = 0; MemWrite = 0;
    endtask

    task automatic test_reset;
        #1 rst = 0;
        #12;
        vectors++; if (dmem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req got=%b want=0", dmem_req); end
        vectors++; if (dmem_we !== 1'b0) begin miscompares++; $display("FAIL reset_we got=%b want=0", dmem_we); end
        vectors++; if (dmem_be !== 4'b0000) begin miscompares++; $display("FAIL reset_be got=%b want=0000", dmem_be); end
        vectors++; if (dmem_addr !== 30'd0) begin miscompares++; $display("FAIL reset_addr got=%h want=0", dmem_addr); end
        vectors++; if (dmem_wdata !== 32'd0) begin miscompares++; $display("FAIL reset_wdata got=%h want=0", dmem_wdata); end
        vectors++; if (memStall !== 1'b0) begin miscompares++; $display("FAIL reset_stall got=%b want=0", memStall); end
        vectors++; if (misalignErr !== 1'b0) begin miscompares++; $display("FAIL reset_mis got=%b want=0", misalignErr); end
        vectors++; if (memoryReadData !== 32'd0) begin miscompares++; $display("FAIL reset_rdata got=%h want=0", memoryReadData); end
        @(negedge clk) rst = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_loads;
        run_access(1, 0, 2'b10, 0, 32'h100, 0, 32'hDEADBEEF, 1);
        vectors++; if (o_addr !== 30'h40) begin miscompares++; $display("FAIL lw_addr got=%h want=40", o_addr); end
        vectors++; if (o_be !== 4'b1111) begin miscompares++; $display("FAIL lw_be got=%b want=1111", o_be); end
        vectors++; if (o_we !== 1'b0) begin miscompares++; $display("FAIL lw_we got=%b want=0", o_we); end
        vectors++; if (o_stall !== 2) begin miscompares++; $display("FAIL lw_stall got=%0d want=2", o_stall); end
        vectors++; if (o_rd !== 32'hDEADBEEF) begin miscompares++; $display("FAIL lw_data got=%h want=deadbeef", o_rd); end
        run_access(1, 0, 2'b00, 0, 32'h103, 0, 32'h80FF7F01, 1);
        vectors++; if (o_rd !== 32'hFFFFFF80) begin miscompares++; $display("FAIL lb_data got=%h want=ffffff80", o_rd); end
        run_access(1, 0, 2'b00, 1, 32'h103, 0, 32'h80FF7F01, 1);
        vectors++; if (o_rd !== 32'h00000080) begin miscompares++; $display("FAIL lbu_data got=%h want=00000080", o_rd); end
        run_access(1, 0, 2'b01, 0, 32'h102, 0, 32'h80FF7F01, 1);
        vectors++; if (o_rd !== 32'hFFFF80FF) begin miscompares++; $display("FAIL lh_data got=%h want=ffff80ff", o_rd); end
    endtask

    task automatic test_stores;
        run_access(0, 1, 2'b00, 0, 32'h201, 32'h000000AB, 0, 1);
        vectors++; if (o_wdata !== 32'hABABABAB) begin miscompares++; $display("FAIL sb_wdata got=%h want=abababab", o_wdata); end
        vectors++; if (o_be !== 4'b0010) begin miscompares++; $display("FAIL sb_be got=%b want=0010", o_be); end
        vectors++; if (o_we !== 1'b1) begin miscompares++; $display("FAIL sb_we got=%b want=1", o_we); end
        run_access(0, 1, 2'b01, 0, 32'h202, 32'h00001234, 0, 1);
        vectors++; if (o_wdata !== 32'h12341234) begin miscompares++; $display("FAIL sh_wdata got=%h want=12341234", o_wdata); end
        vectors++; if (o_be !== 4'b1100) begin miscompares++; $display("FAIL sh_be got=%b want=1100", o_be); end
    endtask

    task automatic test_misalign;
        run_access(1, 0, 2'b10, 0, 32'h102, 0, 32'h11111111, 1);
        vectors++; if (o_mis !== 1'b1) begin miscompares++; $display("FAIL mis_flag got=%b want=1", o_mis); end
        vectors++; if (o_rwe !== 1'b0) begin miscompares++; $display("FAIL mis_regwe got=%b want=0", o_rwe); end
        vectors++; if (o_stall !== 0) begin miscompares++; $display("FAIL mis_stall got=%0d want=0", o_stall); end
        @(negedge clk);
        vectors++; if (misalignErr !== 1'b0) begin miscompares++; $display("FAIL mis_oneshot got=%b want=0", misalignErr); end
        vectors++; if (dmem_req !== 1'b0) begin miscompares++; $display("FAIL mis_noreq got=%b want=0", dmem_req); end
        @(posedge clk); #1;
    endtask

    task automatic test_delayed_ack;
        logic [31:0] w;
        dmem_ack = 1;
        @(negedge clk);
        vectors++; if (dmem_req !== 1'b0 || memStall !== 1'b0) begin miscompares++; $display("FAIL stray_ack req=%b stall=%b want=0/0", dmem_req, memStall); end
        @(posedge clk); #1 dmem_ack = 0;
        @(negedge clk);
        vectors++; if (dmem_req !== 1'b0) begin miscompares++; $display("FAIL stray_ack_after got=%b want=0", dmem_req); end
        @(posedge clk); #1;
        w = $urandom;
        run_access(1, 0, 2'b10, 0, 32'h340, 0, w, 5);
        vectors++; if (o_stall !== 6) begin miscompares++; $display("FAIL delay_stall got=%0d want=6", o_stall); end
        vectors++; if (o_reqcyc !== 5) begin miscompares++; $display("FAIL delay_reqcyc got=%0d want=5", o_reqcyc); end
        vectors++; if (o_stable !== 1'b1 || o_addr !== 30'hD0) begin miscompares++; $display("FAIL delay_stable stable=%b addr=%h want=1/d0", o_stable, o_addr); end
        vectors++; if (o_rd !== w) begin miscompares++; $display("FAIL delay_data got=%h want=%h", o_rd, w); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] w1, w2;
        w1 = $urandom; w2 = $urandom;
        run_access(1, 0, 2'b10, 0, 32'h400, 0, w1, 1);
        vectors++; if (o_rd !== w1 || o_stall !== 2) begin miscompares++; $display("FAIL b2b_first data=%h stall=%0d want=%h/2", o_rd, o_stall, w1); end
        run_access(1, 0, 2'b00, 1, 32'h402, 0, w2, 1);
        vectors++; if (o_rd !== ref_load(w2, 32'h402, 2'b00, 1) || o_stall !== 2) begin miscompares++; $display("FAIL b2b_second data=%h stall=%0d want=%h/2", o_rd, o_stall, ref_load(w2, 32'h402, 2'b00, 1)); end
    endtask

    task automatic test_reset_during_req;
        MemRead = 1; accessSize = 2'b10; ALUResult = 32'h500; dmem_rdata = 32'h55AA55AA;
        @(posedge clk); #1;
        @(negedge clk);
        vectors++; if (dmem_req !== 1'b1) begin miscompares++; $display("FAIL rstreq_pre got=%b want=1", dmem_req); end
        #2 rst = 0;
        #1;
        vectors++; if (dmem_req !== 1'b0 || memStall !== 1'b0) begin miscompares++; $display("FAIL rstreq_now req=%b stall=%b want=0/0", dmem_req, memStall); end
        MemRead = 0;
        #1 rst = 1;
        @(posedge clk); #1 dmem_ack = 1;
        @(negedge clk);
        vectors++; if (dmem_req !== 1'b0 || memStall !== 1'b0 || memoryReadData !== 32'd0) begin miscompares++; $display("FAIL rstreq_ack req=%b stall=%b rd=%h want=0/0/0", dmem_req, memStall, memoryReadData); end
        @(posedge clk); #1 dmem_ack = 0;
        run_access(1, 0, 2'b10, 0, 32'h504, 0, 32'h0BADF00D, 2);
        vectors++; if (o_rd !== 32'h0BADF00D || o_stall !== 3) begin miscompares++; $display("FAIL rstreq_fresh data=%h stall=%0d want=0badf00d/3", o_rd, o_stall); end
    endtask

    task automatic test_random;
        logic rd, wr, uns, mis, ld;
        logic [1:0] sz;
        logic [31:0] a, wd, w;
        int n, op;
        for (int t = 0; t < 40; t++) begin
            op = $urandom_range(0, 2);
            rd = op != 1; wr = op != 0; ld = rd;
            sz = 2'($urandom_range(0, 3)); uns = 1'($urandom_range(0, 1));
            a = $urandom; wd = $urandom; w = $urandom; n = $urandom_range(1, 3);
            if ($urandom_range(0, 3) != 0) a = a - 32'(int'(a[1:0]) % nbytes(sz));
            mis = ref_mis(a, sz);
            run_access(rd, wr, sz, uns, a, wd, w, n);
            vectors++; if (o_mis !== mis) begin miscompares++; $display("FAIL rnd_mis t=%0d got=%b want=%b", t, o_mis, mis); end
            vectors++; if (o_stall !== (mis ? 0 : n + 1)) begin miscompares++; $display("FAIL rnd_stall t=%0d got=%0d want=%0d", t, o_stall, mis ? 0 : n + 1); end
            if (!mis) begin
                vectors++; if (o_addr !== a[31:2] || o_be !== ref_be(a, sz) || o_we !== !ld) begin miscompares++; $display("FAIL rnd_port t=%0d addr=%h be=%b we=%b want=%h/%b/%b", t, o_addr, o_be, o_we, a[31:2], ref_be(a, sz), !ld); end
                if (ld) begin
                    vectors++; if (o_rd !== ref_load(w, a, sz, uns)) begin miscompares++; $display("FAIL rnd_load t=%0d got=%h want=%h", t, o_rd, ref_load(w, a, sz, uns)); end
                end else begin
                    vectors++; if (o_wdata !== ref_wdata(wd, sz)) begin miscompares++; $display("FAIL rnd_store t=%0d got=%h want=%h", t, o_wdata, ref_wdata(wd, sz)); end
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_loads;
        test_stores;
        test_misalign;
        test_delayed_ack;
        test_back_to_back;
        test_reset_during_req;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
